// File: rtl/ex_types_pkg.sv
// Shared execute-stage types: operation encoding, register-number width and
// the multiply sequencer states.
package ex_types_pkg;

  localparam int EXOP_W = 4;
  localparam int REG_W  = 5;

  typedef enum logic [EXOP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_LUI  = 4'd10,
    OP_MUL  = 4'd11
  } exop_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/ex_mul_unit.sv
// Multi-cycle multiplier sequencer: latches operands on start, counts out the
// latency (holding while frozen) and pulses done on the final cycle.
module ex_mul_unit
  import ex_types_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              freeze_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] prod_o
);

  localparam int               CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  mul_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // Sequencer: the accept cycle counts as step 0, so the counter starts at 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {DATA_W{1'b0}};
      b_q     <= {DATA_W{1'b0}};
    end else if (abort_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else if (!freeze_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_MUL;
            cnt_q   <= CNT_W'(1);
            a_q     <= a_i;
            b_q     <= b_i;
          end
        end
        ST_MUL: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy_o = (state_q == ST_MUL);
  assign done_o = busy_o && (cnt_q == CNT_LAST) && !abort_i && !freeze_i;
  assign prod_o = a_q * b_q;

endmodule

// File: rtl/ex_fwd_stage.sv
// Execute stage: priority operand forwarding over FWD_SRCS producers, ALU,
// multi-cycle multiply and the EX/MEM register with stall and deferred flush.
module ex_fwd_stage
  import ex_types_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FWD_SRCS = 2,
  parameter int MUL_LAT  = 4,
  parameter int CTRL_W   = 12
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       in_valid,
  output logic                       ex_ready,
  input  logic                       mem_stall,
  input  logic                       flush,
  input  exop_t                      exop,
  input  logic                       immtype,
  input  logic [DATA_W-1:0]          portA,
  input  logic [DATA_W-1:0]          portB,
  input  logic [DATA_W-1:0]          extOut,
  input  logic [REG_W-1:0]           rs,
  input  logic [REG_W-1:0]           rt,
  input  logic [REG_W-1:0]           wreg,
  input  logic [CTRL_W-1:0]          ctrl_in,
  input  logic [FWD_SRCS-1:0]        fwd_wen,
  input  logic [FWD_SRCS*REG_W-1:0]  fwd_wreg,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_data,
  output logic                       valid_r,
  output logic [DATA_W-1:0]          portOut_r,
  output logic                       Zero_r,
  output logic [DATA_W-1:0]          dstore_r,
  output logic [REG_W-1:0]           wreg_r,
  output logic [CTRL_W-1:0]          ctrl_r,
  output logic                       busy
);

  localparam bit MUL_MULTI = (MUL_LAT > 1) ? 1'b1 : 1'b0;

  logic [FWD_SRCS-1:0] hit_a_s;
  logic [FWD_SRCS-1:0] hit_b_s;
  logic [DATA_W-1:0]   src_data_s [FWD_SRCS];
  logic [DATA_W-1:0]   fwd_a_s, fwd_b_s, opb_s, alu_res_s, mul_prod_s;
  logic                is_mul_multi_s, accept_s, kill_s, mul_start_s, mul_done_s;
  logic                flush_pend_q;
  logic [REG_W-1:0]    mul_wreg_q;
  logic [CTRL_W-1:0]   mul_ctrl_q;
  logic [DATA_W-1:0]   mul_dstore_q;
  logic                valid_d, zero_d;
  logic [DATA_W-1:0]   res_d, dstore_d;
  logic [REG_W-1:0]    wreg_d;
  logic [CTRL_W-1:0]   ctrl_d;

  for (genvar i = 0; i < FWD_SRCS; i++) begin : g_fwd
    assign src_data_s[i] = fwd_data[i*DATA_W +: DATA_W];
    assign hit_a_s[i]    = fwd_wen[i] && (rs != {REG_W{1'b0}}) &&
                           (fwd_wreg[i*REG_W +: REG_W] == rs);
    assign hit_b_s[i]    = fwd_wen[i] && (rt != {REG_W{1'b0}}) &&
                           (fwd_wreg[i*REG_W +: REG_W] == rt);
  end

  // Priority pick: scanning oldest to youngest lets the lowest index win.
  always_comb begin
    fwd_a_s = portA;
    fwd_b_s = portB;
    for (int i = FWD_SRCS - 1; i >= 0; i--) begin
      fwd_a_s = hit_a_s[i] ? src_data_s[i] : fwd_a_s;
      fwd_b_s = hit_b_s[i] ? src_data_s[i] : fwd_b_s;
    end
  end

  assign opb_s          = immtype ? extOut : fwd_b_s;
  assign ex_ready       = !busy && !mem_stall;
  assign accept_s       = in_valid && ex_ready;
  assign kill_s         = !mem_stall && (flush || flush_pend_q);
  assign is_mul_multi_s = MUL_MULTI && (exop == OP_MUL);
  assign mul_start_s    = accept_s && is_mul_multi_s && !kill_s;

  // ALU result for single-cycle operations.
  always_comb begin
    alu_res_s = {DATA_W{1'b0}};
    case (exop)
      OP_ADD:  alu_res_s = fwd_a_s + opb_s;
      OP_SUB:  alu_res_s = fwd_a_s - opb_s;
      OP_AND:  alu_res_s = fwd_a_s & opb_s;
      OP_OR:   alu_res_s = fwd_a_s | opb_s;
      OP_XOR:  alu_res_s = fwd_a_s ^ opb_s;
      OP_NOR:  alu_res_s = ~(fwd_a_s | opb_s);
      OP_SLT:  alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(fwd_a_s) < $signed(opb_s))};
      OP_SLTU: alu_res_s = {{(DATA_W-1){1'b0}}, (fwd_a_s < opb_s)};
      OP_SLL:  alu_res_s = fwd_a_s << opb_s[4:0];
      OP_SRL:  alu_res_s = fwd_a_s >> opb_s[4:0];
      OP_LUI:  alu_res_s = opb_s << 5'd16;
      OP_MUL:  alu_res_s = fwd_a_s * opb_s;
      default: alu_res_s = {DATA_W{1'b0}};
    endcase
  end

  ex_mul_unit #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk_i    (CLK),
    .rst_ni   (nRST),
    .start_i  (mul_start_s),
    .abort_i  (kill_s),
    .freeze_i (mem_stall),
    .a_i      (fwd_a_s),
    .b_i      (opb_s),
    .busy_o   (busy),
    .done_o   (mul_done_s),
    .prod_o   (mul_prod_s)
  );

  // A flush that arrives while MEM is stalled must survive until the stall lifts.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flush_pend_q <= 1'b0;
    end else if (mem_stall) begin
      flush_pend_q <= flush_pend_q | flush;
    end else begin
      flush_pend_q <= 1'b0;
    end
  end

  // Side-band of an in-flight multiply, replayed into EX/MEM with the product.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mul_wreg_q   <= {REG_W{1'b0}};
      mul_ctrl_q   <= {CTRL_W{1'b0}};
      mul_dstore_q <= {DATA_W{1'b0}};
    end else if (mul_start_s) begin
      mul_wreg_q   <= wreg;
      mul_ctrl_q   <= ctrl_in;
      mul_dstore_q <= fwd_b_s;
    end
  end

  // EX/MEM next state; anything not producing a result becomes an all-zero bubble.
  always_comb begin
    valid_d  = 1'b0;
    res_d    = {DATA_W{1'b0}};
    dstore_d = {DATA_W{1'b0}};
    wreg_d   = {REG_W{1'b0}};
    ctrl_d   = {CTRL_W{1'b0}};
    if (kill_s) begin
      valid_d = 1'b0;
    end else if (busy) begin
      if (mul_done_s) begin
        valid_d  = 1'b1;
        res_d    = mul_prod_s;
        dstore_d = mul_dstore_q;
        wreg_d   = mul_wreg_q;
        ctrl_d   = mul_ctrl_q;
      end else begin
        valid_d = 1'b0;
      end
    end else if (in_valid && !is_mul_multi_s) begin
      valid_d  = 1'b1;
      res_d    = alu_res_s;
      dstore_d = fwd_b_s;
      wreg_d   = wreg;
      ctrl_d   = ctrl_in;
    end else begin
      valid_d = 1'b0;
    end
  end

  assign zero_d = valid_d && (res_d == {DATA_W{1'b0}});

  // EX/MEM pipeline register, held while MEM is stalled.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_r   <= 1'b0;
      portOut_r <= {DATA_W{1'b0}};
      Zero_r    <= 1'b0;
      dstore_r  <= {DATA_W{1'b0}};
      wreg_r    <= {REG_W{1'b0}};
      ctrl_r    <= {CTRL_W{1'b0}};
    end else if (!mem_stall) begin
      valid_r   <= valid_d;
      portOut_r <= res_d;
      Zero_r    <= zero_d;
      dstore_r  <= dstore_d;
      wreg_r    <= wreg_d;
      ctrl_r    <= ctrl_d;
    end
  end

endmodule

// File: tb/tb_ex_fwd_stage.sv
// Scoreboard bench for ex_fwd_stage: stimulus pushes expected EX/MEM contents,
// a monitor pops and compares each freshly loaded valid output.
module tb_ex_fwd_stage;
  import ex_types_pkg::*;

  localparam int DATA_W = 32, FWD_SRCS = 2, MUL_LAT = 4, CTRL_W = 12;

  logic CLK, nRST, in_valid, ex_ready, mem_stall, flush, immtype;
  exop_t exop;
  logic [31:0] portA, portB, extOut;
  logic [4:0]  rs, rt, wreg;
  logic [11:0] ctrl_in;
  logic [1:0]  fwd_wen;
  logic [9:0]  fwd_wreg;
  logic [63:0] fwd_data;
  logic        valid_r, Zero_r, busy;
  logic [31:0] portOut_r, dstore_r;
  logic [4:0]  wreg_r;
  logic [11:0] ctrl_r;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] dst;
    logic [4:0]  wr;
    logic [11:0] ct;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;

  ex_fwd_stage #(.DATA_W(DATA_W), .FWD_SRCS(FWD_SRCS), .MUL_LAT(MUL_LAT), .CTRL_W(CTRL_W)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .ex_ready(ex_ready),
    .mem_stall(mem_stall), .flush(flush), .exop(exop), .immtype(immtype),
    .portA(portA), .portB(portB), .extOut(extOut), .rs(rs), .rt(rt), .wreg(wreg),
    .ctrl_in(ctrl_in), .fwd_wen(fwd_wen), .fwd_wreg(fwd_wreg), .fwd_data(fwd_data),
    .valid_r(valid_r), .portOut_r(portOut_r), .Zero_r(Zero_r), .dstore_r(dstore_r),
    .wreg_r(wreg_r), .ctrl_r(ctrl_r), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic issue(input exop_t op, input logic imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ext, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] w, input logic [11:0] c,
                       input logic push, input logic [31:0] er, input logic [31:0] ed);
    exop = op; immtype = imm; portA = a; portB = b; extOut = ext;
    rs = s; rt = t; wreg = w; ctrl_in = c; in_valid = 1'b1;
    if (push) exp_q.push_back('{res: er, dst: ed, wr: w, ct: c});
    @(negedge CLK);
  endtask

  // Monitor: compare only when EX/MEM was actually loaded at the last edge.
  initial begin : monitor
    logic upd;
    exp_t e;
    forever begin
      @(posedge CLK);
      upd = nRST && !mem_stall;
      @(negedge CLK);
      if (upd && valid_r) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got portOut_r 0x%0h, required no valid output", portOut_r);
        end else begin
          e = exp_q.pop_front();
          chk("portOut_r", portOut_r, e.res);
          chk("Zero_r", 32'(Zero_r), 32'(e.res == 32'd0));
          chk("dstore_r", dstore_r, e.dst);
          chk("wreg_r", 32'(wreg_r), 32'(e.wr));
          chk("ctrl_r", 32'(ctrl_r), 32'(e.ct));
        end
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0;
    nRST = 1'b0; in_valid = 1'b0; mem_stall = 1'b0; flush = 1'b0; immtype = 1'b0;
    exop = OP_ADD; portA = 32'd0; portB = 32'd0; extOut = 32'd0;
    rs = 5'd0; rt = 5'd0; wreg = 5'd0; ctrl_in = 12'd0;
    fwd_wen = 2'b00; fwd_wreg = 10'd0; fwd_data = 64'd0;

    #12;
    chk("reset_valid_r", 32'(valid_r), 32'd0);
    chk("reset_portOut_r", portOut_r, 32'd0);
    chk("reset_Zero_r", 32'(Zero_r), 32'd0);
    chk("reset_ctrl_r", 32'(ctrl_r), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ex_ready", 32'(ex_ready), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;

    issue(OP_ADD, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 5'd4, 5'd9, 12'h0a1, 1'b1, 32'd12, 32'd7);

    // Forwarding: index 0 outranks index 1, register 0 never forwards.
    fwd_wen = 2'b11; fwd_wreg = {5'd3, 5'd3}; fwd_data = {32'h20, 32'h10};
    issue(OP_ADD, 1'b0, 32'h100, 32'h1, 32'd0, 5'd3, 5'd0, 5'd10, 12'h0a2, 1'b1, 32'h11, 32'h1);
    issue(OP_ADD, 1'b0, 32'h100, 32'h1, 32'd0, 5'd0, 5'd3, 5'd11, 12'h0a3, 1'b1, 32'h110, 32'h10);
    fwd_wen = 2'b10;
    issue(OP_SUB, 1'b0, 32'h100, 32'h20, 32'd0, 5'd3, 5'd5, 5'd12, 12'h0a4, 1'b1, 32'h0, 32'h20);
    fwd_wen = 2'b00;

    issue(OP_SUB,  1'b0, 32'd3, 32'd5, 32'd0, 5'd1, 5'd2, 5'd13, 12'h101, 1'b1, 32'hFFFF_FFFE, 32'd5);
    issue(OP_AND,  1'b0, 32'hF0F0, 32'hFF00, 32'd0, 5'd1, 5'd2, 5'd14, 12'h102, 1'b1, 32'hF000, 32'hFF00);
    issue(OP_OR,   1'b0, 32'hF0, 32'h0F, 32'd0, 5'd1, 5'd2, 5'd15, 12'h103, 1'b1, 32'hFF, 32'h0F);
    issue(OP_XOR,  1'b0, 32'hFF, 32'h0F, 32'd0, 5'd1, 5'd2, 5'd16, 12'h104, 1'b1, 32'hF0, 32'h0F);
    issue(OP_NOR,  1'b0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd17, 12'h105, 1'b1, 32'hFFFF_FFFF, 32'd0);
    issue(OP_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd2, 5'd18, 12'h106, 1'b1, 32'd1, 32'd1);
    issue(OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd2, 5'd19, 12'h107, 1'b1, 32'd0, 32'd1);
    issue(OP_SLL,  1'b1, 32'd1, 32'hDEAD, 32'd31, 5'd1, 5'd2, 5'd20, 12'h108, 1'b1, 32'h8000_0000, 32'hDEAD);
    issue(OP_SRL,  1'b0, 32'h8000_0000, 32'h24, 32'd0, 5'd1, 5'd2, 5'd21, 12'h109, 1'b1, 32'h0800_0000, 32'h24);
    issue(OP_LUI,  1'b1, 32'd0, 32'd0, 32'h1234, 5'd1, 5'd2, 5'd22, 12'h10a, 1'b1, 32'h1234_0000, 32'd0);
    issue(OP_ADD,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd2, 5'd23, 12'h10b, 1'b1, 32'd0, 32'd1);

    // Stall holds a valid EX/MEM result and blocks acceptance.
    issue(OP_ADD, 1'b0, 32'd100, 32'd23, 32'd0, 5'd1, 5'd2, 5'd24, 12'h201, 1'b1, 32'd123, 32'd23);
    mem_stall = 1'b1;
    portA = 32'd1; portB = 32'd1; wreg = 5'd25;
    #1;
    chk("stall_ex_ready", 32'(ex_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("stall_hold_portOut_r", portOut_r, 32'd123);
      chk("stall_hold_valid_r", 32'(valid_r), 32'd1);
    end
    mem_stall = 1'b0;
    issue(OP_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 5'd1, 5'd2, 5'd25, 12'h202, 1'b1, 32'd2, 32'd1);

    // Multiply: three bubbles then the wrapped product.
    issue(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd1, 5'd2, 5'd7, 12'h03c, 1'b1, 32'hFFFF_FFFE, 32'd2);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_bubble_valid_r", 32'(valid_r), 32'd0);
      chk("mul_bubble_ctrl_r", 32'(ctrl_r), 32'd0);
      chk("mul_ex_ready", 32'(ex_ready), 32'd0);
      @(negedge CLK);
    end
    chk("mul_done_busy", 32'(busy), 32'd0);
    chk("mul_done_ex_ready", 32'(ex_ready), 32'd1);

    // Multiply with a 3-cycle stall in the middle: result 3 cycles late.
    issue(OP_MUL, 1'b0, 32'd6, 32'd7, 32'd0, 5'd1, 5'd2, 5'd8, 12'h03d, 1'b1, 32'd42, 32'd7);
    in_valid = 1'b0;
    @(negedge CLK);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("mulstall_busy", 32'(busy), 32'd1);
      chk("mulstall_valid_r", 32'(valid_r), 32'd0);
    end
    mem_stall = 1'b0;
    @(negedge CLK);
    chk("mulstall_late_busy", 32'(busy), 32'd1);
    chk("mulstall_late_valid_r", 32'(valid_r), 32'd0);
    @(negedge CLK);
    chk("mulstall_done_busy", 32'(busy), 32'd0);

    // Flush without stall turns the incoming instruction into a bubble.
    flush = 1'b1;
    issue(OP_ADD, 1'b0, 32'd9, 32'd9, 32'd0, 5'd1, 5'd2, 5'd26, 12'h301, 1'b0, 32'd0, 32'd0);
    flush = 1'b0;
    chk("flush_valid_r", 32'(valid_r), 32'd0);

    // Flush during a stall aborts the in-flight multiply once the stall lifts.
    issue(OP_MUL, 1'b0, 32'd3, 32'd3, 32'd0, 5'd1, 5'd2, 5'd27, 12'h302, 1'b0, 32'd0, 32'd0);
    in_valid = 1'b0;
    mem_stall = 1'b1; flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    @(negedge CLK);
    chk("flushpend_busy_in_stall", 32'(busy), 32'd1);
    mem_stall = 1'b0;
    @(negedge CLK);
    chk("flushpend_busy", 32'(busy), 32'd0);
    chk("flushpend_valid_r", 32'(valid_r), 32'd0);
    chk("flushpend_ex_ready", 32'(ex_ready), 32'd1);
    issue(OP_ADD, 1'b0, 32'd2, 32'd2, 32'd0, 5'd1, 5'd2, 5'd28, 12'h303, 1'b1, 32'd4, 32'd2);

    // Asynchronous reset in the middle of a multiply.
    issue(OP_MUL, 1'b0, 32'd5, 32'd5, 32'd0, 5'd1, 5'd2, 5'd29, 12'h304, 1'b0, 32'd0, 32'd0);
    in_valid = 1'b0;
    chk("rstmul_busy_before", 32'(busy), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("rstmul_busy", 32'(busy), 32'd0);
    chk("rstmul_valid_r", 32'(valid_r), 32'd0);
    chk("rstmul_wreg_r", 32'(wreg_r), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rstmul_ex_ready", 32'(ex_ready), 32'd1);
    @(negedge CLK);
    issue(OP_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd30, 12'h305, 1'b1, 32'd3, 32'd2);

    in_valid = 1'b0;
    repeat (6) @(negedge CLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
